// File: rtl/pastillero_resp.sv
// -----------------------------------------------------------------------------
// pastillero_resp -- sensor responder for the pill-dispenser controller.
//
// Watches the controller's one-hot stage code E. Each change of E to a
// nonzero value is an event. A one-hot event moves step to its index and
// may make a sensor decision:
//   w decides on index 0, x on index 7, y on index 8, z on index 9.
// A sensor answers "fail" (0) until it has failed *_FAILS times in the
// current dose, then answers "pass" (1). An index-0 event arriving from
// step 10 completes a dose: dose_cnt increments and every fail counter
// restarts from zero.
//
// Optional feature: define PASTILLERO_CHECK_EN to compile in the protocol
// checker (one-hot check and stage successor table), which drives err.
// Without it err is tied low and non-one-hot codes are silently ignored.
//
// Ports:
//   clk       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   E[10:0]   in   one-hot stage code, bit k = controller just left stage Sk
//   w,x,y,z   out  sensor levels returned to the controller
//   step[3:0] out  index of the last accepted stage, 4'hF when none
//   dose_cnt  out  completed-dose counter, wraps 255 -> 0
//   err       out  sticky protocol-error flag
// -----------------------------------------------------------------------------
module pastillero_resp #(
  parameter logic [3:0] W_FAILS = 4'd0,
  parameter logic [3:0] X_FAILS = 4'd1,
  parameter logic [3:0] Y_FAILS = 4'd0,
  parameter logic [3:0] Z_FAILS = 4'd0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [10:0] E,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  step,
  output logic [7:0]  dose_cnt,
  output logic        err
);

  // Per-sensor fail limits and deciding stage, packed w,x,y,z from LSB.
  localparam logic [15:0] FAILS   = {Z_FAILS, Y_FAILS, X_FAILS, W_FAILS};
  localparam logic [15:0] DEC_IDX = {4'd9, 4'd8, 4'd7, 4'd0};
  localparam logic [3:0]  NO_STEP = 4'hF;

  logic [10:0] e_q;
  logic [3:0]  step_reg;
  logic [7:0]  dose_reg;
  logic [3:0]  sens;
  logic [3:0]  idx;
  logic        changed;
  logic        one_hot;
  logic        accept;
  logic        dose_done;

  // A change to all-zero is the idle code and never an event.
  assign changed   = (E != e_q) && (E != 11'd0);
  assign one_hot   = ((E & (E - 11'd1)) == 11'd0);
  assign accept    = changed && one_hot;
  assign dose_done = accept && (idx == 4'd0) && (step_reg == 4'd10);

  // One-hot to binary; only meaningful when one_hot is true.
  always_comb begin
    idx = 4'd0;
    for (int k = 0; k < 11; k++) begin
      if (E[k]) begin
        idx = idx | 4'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      e_q      <= 11'd0;
      step_reg <= NO_STEP;
      dose_reg <= 8'd0;
    end else begin
      e_q <= E;
      if (accept) begin
        step_reg <= idx;
      end
      if (dose_done) begin
        dose_reg <= dose_reg + 8'd1;
      end
    end
  end

  // One fail counter and one output level per sensor.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sensor
      logic [3:0] cnt_reg;
      logic       sens_reg;
      logic [3:0] cnt_eff;
      logic [3:0] limit;

      assign limit = FAILS[gi*4 +: 4];
      // A completing dose restarts the count before w is judged on the
      // same edge, so the decision sees the cleared value.
      assign cnt_eff = dose_done ? 4'd0 : cnt_reg;

      always_ff @(posedge clk) begin
        if (RST) begin
          cnt_reg  <= 4'd0;
          sens_reg <= 1'b0;
        end else if (accept) begin
          if (idx == DEC_IDX[gi*4 +: 4]) begin
            sens_reg <= (cnt_eff >= limit);
            cnt_reg  <= (cnt_eff < limit) ? cnt_eff + 4'd1 : cnt_eff;
          end else begin
            cnt_reg  <= cnt_eff;
          end
        end
      end

      assign sens[gi] = sens_reg;
    end
  endgenerate

`ifdef PASTILLERO_CHECK_EN
  // Allowed stage successors; an unknown previous step accepts anything.
  function automatic logic succ_ok(input logic [3:0] prev, input logic [3:0] nxt);
    case (prev)
      4'd0:    succ_ok = (nxt == 4'd1);
      4'd1:    succ_ok = (nxt == 4'd2) || (nxt == 4'd0);
      4'd2:    succ_ok = (nxt == 4'd3);
      4'd3:    succ_ok = (nxt == 4'd4);
      4'd4:    succ_ok = (nxt == 4'd5);
      4'd5:    succ_ok = (nxt == 4'd6);
      4'd6:    succ_ok = (nxt == 4'd7);
      4'd7:    succ_ok = (nxt == 4'd8);
      4'd8:    succ_ok = (nxt == 4'd9) || (nxt == 4'd7);
      4'd9:    succ_ok = (nxt == 4'd10) || (nxt == 4'd5);
      4'd10:   succ_ok = (nxt == 4'd0) || (nxt == 4'd2);
      4'hF:    succ_ok = 1'b1;
      default: succ_ok = 1'b0;
    endcase
  endfunction

  logic err_reg;
  logic bad_code;
  logic bad_seq;

  // Illegal successors still move step; only a bad code is rejected.
  assign bad_code = changed && !one_hot;
  assign bad_seq  = accept && !succ_ok(step_reg, idx);

  always_ff @(posedge clk) begin
    if (RST) begin
      err_reg <= 1'b0;
    end else if (bad_code || bad_seq) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign w        = sens[0];
  assign x        = sens[1];
  assign y        = sens[2];
  assign z        = sens[3];
  assign step     = step_reg;
  assign dose_cnt = dose_reg;

endmodule

// File: tb/tb_pastillero_resp.sv
// -----------------------------------------------------------------------------
// tb_pastillero_resp -- self-checking bench for pastillero_resp.
// Drives stage codes, keeps a behavioural model of the responder and compares
// every DUT output after each applied code. Honours PASTILLERO_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_pastillero_resp;

  localparam logic [3:0] P_W = 4'd2;
  localparam logic [3:0] P_X = 4'd1;
  localparam logic [3:0] P_Y = 4'd0;
  localparam logic [3:0] P_Z = 4'd3;
`ifdef PASTILLERO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [10:0] E;
  logic        w, x, y, z;
  logic [3:0]  step;
  logic [7:0]  dose_cnt;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  pastillero_resp #(
    .W_FAILS(P_W),
    .X_FAILS(P_X),
    .Y_FAILS(P_Y),
    .Z_FAILS(P_Z)
  ) dut (
    .clk(clk),
    .RST(RST),
    .E(E),
    .w(w),
    .x(x),
    .y(y),
    .z(z),
    .step(step),
    .dose_cnt(dose_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_step;      // -1 means no stage seen yet
  int          m_cnt[4];
  bit          m_sens[4];
  int          m_dose;
  bit          m_err;
  logic [10:0] m_prev;
  int          m_fails[4];
  int          m_dec[4];

  function automatic bit is_succ(int a, int b);
    return (a < 10 && b == a + 1) || (a == 1 && b == 0) || (a == 8 && b == 7) ||
           (a == 9 && b == 5) || (a == 10 && (b == 0 || b == 2));
  endfunction

  function automatic int pick_next(int s);
    int q[$];
    if (s < 0) return 0;
    for (int b = 0; b <= 10; b++) if (is_succ(s, b)) q.push_back(b);
    return q[$urandom_range(q.size() - 1)];
  endfunction

  task automatic model_edge(input logic rst, input logic [10:0] e);
    int k;
    if (rst) begin
      m_step = -1;
      m_dose = 0;
      m_err  = 1'b0;
      m_prev = '0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i]  = 0;
        m_sens[i] = 1'b0;
      end
    end else begin
      if (e != m_prev && e != 11'd0) begin
        if ($countones(e) != 1) begin
          if (CHK) m_err = 1'b1;
        end else begin
          k = 0;
          for (int b = 0; b < 11; b++) if (e[b]) k = b;
          if (CHK && m_step >= 0 && !is_succ(m_step, k)) m_err = 1'b1;
          if (k == 0 && m_step == 10) begin
            m_dose = (m_dose + 1) % 256;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          end
          for (int i = 0; i < 4; i++) begin
            if (m_dec[i] == k) begin
              m_sens[i] = (m_cnt[i] >= m_fails[i]);
              if (m_cnt[i] < m_fails[i]) m_cnt[i]++;
            end
          end
          m_step = k;
        end
      end
      m_prev = e;
    end
  endtask

  function automatic logic [16:0] expv();
    logic [3:0] s;
    s = (m_step < 0) ? 4'hF : 4'(m_step);
    return {m_sens[0], m_sens[1], m_sens[2], m_sens[3], s, 8'(m_dose), m_err};
  endfunction

  function automatic logic [16:0] actv();
    return {w, x, y, z, step, dose_cnt, err};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge(RST, E);
    #1;
  endtask

  task automatic apply(input logic [10:0] v);
    E = v;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick();
    E = 11'd0;
    RST = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    E = 11'h010;
    repeat (2) tick();
    n_checks++;
    if (actv() !== 17'h1E00)
      $display("FAIL reset_values: outputs=%h required=%h", actv(), 17'h1E00);
    else n_pass++;
    E = 11'd0;
    RST = 1'b0;
    tick();
    n_checks++;
    if (actv() !== expv())
      $display("FAIL reset_release: outputs=%h required=%h", actv(), expv());
    else n_pass++;
    $display("txn reset: step=%h dose=%0d err=%0d", step, dose_cnt, err);
  endtask

  task automatic test_dose_walk();
    int seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 8, 9, 10, 0};
    for (int i = 0; i < 14; i++) begin
      apply(11'd1 << seq[i]);
      $display("txn walk idx=%0d: wxyz=%b%b%b%b step=%0d dose=%0d err=%0d",
               seq[i], w, x, y, z, step, dose_cnt, err);
      n_checks++;
      if (actv() !== expv())
        $display("FAIL walk[%0d]: outputs=%h required=%h", i, actv(), expv());
      else n_pass++;
      if (i == 7 || i == 9) begin
        // X_FAILS=1: first x decision fails, second passes
        n_checks++;
        if (x !== (i == 9))
          $display("FAIL walk_x[%0d]: x=%b required=%b", i, x, (i == 9));
        else n_pass++;
      end
    end
    n_checks++;
    if (dose_cnt !== 8'd1 || err !== 1'b0)
      $display("FAIL walk_end: dose=%0d err=%b required dose=1 err=0", dose_cnt, err);
    else n_pass++;
  endtask

  task automatic test_bad_onehot();
    do_reset();
    apply(11'd1 << 0);
    apply(11'd1 << 1);
    apply(11'h003);
    $display("txn bad_code: step=%0d err=%0d", step, err);
    n_checks++;
    if (step !== 4'd1 || err !== CHK)
      $display("FAIL bad_code: step=%0d err=%b required step=1 err=%b", step, err, CHK);
    else n_pass++;
    n_checks++;
    if (actv() !== expv())
      $display("FAIL bad_code_model: outputs=%h required=%h", actv(), expv());
    else n_pass++;
    apply(11'd1 << 2);
    n_checks++;
    if (actv() !== expv())
      $display("FAIL bad_code_next: outputs=%h required=%h", actv(), expv());
    else n_pass++;
  endtask

  task automatic test_illegal_jump();
    int nx;
    do_reset();
    for (int i = 0; i <= 3; i++) apply(11'd1 << i);
    apply(11'd1 << 6);
    $display("txn jump 3->6: step=%0d err=%0d", step, err);
    n_checks++;
    if (step !== 4'd6 || err !== CHK)
      $display("FAIL jump: step=%0d err=%b required step=6 err=%b", step, err, CHK);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      nx = pick_next(m_step);
      apply(11'd1 << nx);
      $display("txn jump_follow idx=%0d: step=%0d err=%0d", nx, step, err);
      n_checks++;
      if (actv() !== expv())
        $display("FAIL jump_follow[%0d]: outputs=%h required=%h", i, actv(), expv());
      else n_pass++;
    end
    n_checks++;
    if (err !== CHK)
      $display("FAIL jump_sticky: err=%b required=%b", err, CHK);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i <= 8; i++) apply(11'd1 << i);
    RST = 1'b1;
    tick();
    n_checks++;
    if (actv() !== 17'h1E00)
      $display("FAIL reset_mid: outputs=%h required=%h", actv(), 17'h1E00);
    else n_pass++;
    E = 11'd1 << 5;
    tick();
    RST = 1'b0;
    repeat (2) tick();
    $display("txn reset_mid then idx=5: step=%0d err=%0d", step, err);
    n_checks++;
    if (step !== 4'd5 || err !== 1'b0)
      $display("FAIL reset_mid_first: step=%0d err=%b required step=5 err=0", step, err);
    else n_pass++;
    n_checks++;
    if (actv() !== expv())
      $display("FAIL reset_mid_model: outputs=%h required=%h", actv(), expv());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] v;
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(99);
      if (r < 80) v = 11'd1 << pick_next(m_step);
      else if (r < 88) v = 11'd1 << $urandom_range(10);
      else if (r < 94) begin
        v = 11'($urandom);
        if ($countones(v) < 2) v = 11'h600;
      end else v = 11'd0;
      apply(v);
      $display("txn rand[%0d] E=%h: wxyz=%b%b%b%b step=%0d dose=%0d err=%0d",
               i, v, w, x, y, z, step, dose_cnt, err);
      n_checks++;
      if (actv() !== expv())
        $display("FAIL rand[%0d]: outputs=%h required=%h", i, actv(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_many_doses();
    int q[$];
    bit first_x;
    do_reset();
    for (int d = 0; d < 256; d++) begin
      q = '{0, 1, 2, 3, 4, 5, 6, 7};
      repeat ($urandom_range(2)) begin q.push_back(8); q.push_back(7); end
      q.push_back(8);
      q.push_back(9);
      if ($urandom_range(1) == 1) begin
        q.push_back(5); q.push_back(6); q.push_back(7); q.push_back(8); q.push_back(9);
      end
      if ($urandom_range(1) == 1) begin
        q.push_back(10);
        for (int s = 2; s <= 9; s++) q.push_back(s);
      end
      q.push_back(10);
      first_x = 1'b1;
      foreach (q[i]) begin
        apply(11'd1 << q[i]);
        n_checks++;
        if (actv() !== expv())
          $display("FAIL dose%0d[%0d]: outputs=%h required=%h", d, i, actv(), expv());
        else n_pass++;
        if (q[i] == 0) begin
          n_checks++;
          if (w !== (P_W == 4'd0))
            $display("FAIL dose%0d_w: w=%b required=%b", d, w, (P_W == 4'd0));
          else n_pass++;
        end
        if (q[i] == 7 && first_x) begin
          first_x = 1'b0;
          n_checks++;
          if (x !== (P_X == 4'd0))
            $display("FAIL dose%0d_x: x=%b required=%b", d, x, (P_X == 4'd0));
          else n_pass++;
        end
      end
      $display("txn dose %0d: events=%0d dose_cnt=%0d err=%0d", d, q.size(), dose_cnt, err);
    end
    apply(11'd1 << 0);
    n_checks++;
    if (dose_cnt !== 8'd0 || err !== 1'b0)
      $display("FAIL dose_wrap: dose=%0d err=%b required dose=0 err=0", dose_cnt, err);
    else n_pass++;
  endtask

  initial begin
    m_fails = '{int'(P_W), int'(P_X), int'(P_Y), int'(P_Z)};
    m_dec   = '{0, 7, 8, 9};
    m_step  = -1;
    m_dose  = 0;
    m_err   = 1'b0;
    m_prev  = '0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_sens[i] = 1'b0;
    end
    RST = 1'b1;
    E   = 11'd0;
    test_reset();
    test_dose_walk();
    test_bad_onehot();
    test_illegal_jump();
    test_reset_mid();
    test_random();
    test_many_doses();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
